// File: rtl/cpu7_trap_ctrl.sv
// cpu7 trap/return sequencer: arbitrates interrupts, illegal-instruction
// exceptions and mret. It drains the pipeline with a req/ack handshake,
// then issues one-cycle PC-flush and mepc/mcause update pulses.
module cpu7_trap_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned N_IRQ       = 4,
  parameter int unsigned VECTORED_EN = 1,
  parameter int unsigned DRAIN_TMO   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic             mstatus_mie,
  input  logic             illinstr,
  input  logic             mret,
  input  logic [XLEN-1:0]  cur_pc,
  input  logic [XLEN-1:0]  csr_mtvec,
  input  logic [XLEN-1:0]  csr_mepc,
  input  logic             drain_ack,
  output logic             drain_req,
  output logic             stall_f,
  output logic             kill_d,
  output logic             flush_pc_ena,
  output logic [XLEN-1:0]  flush_pc,
  output logic [XLEN-1:0]  mepc_wdata,
  output logic             mepc_we,
  output logic [XLEN-1:0]  mcause_wdata,
  output logic             mcause_we,
  output logic             drain_tmo_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]      state_q;
  logic            ret_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_q;
  logic [7:0]      cnt_q;
  logic            tmo_err_q;

  logic [N_IRQ-1:0] pend;
  logic             any_irq;
  logic             irq_found;
  logic [4:0]       irq_code;
  logic             event_hit;
  logic [XLEN-1:0]  cause_n;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  target_n;
  logic             unused_mtvec_bit;

  // mcause code for an interrupt channel index
  function automatic logic [4:0] chan_code(input int unsigned ch);
    if (ch == 0)      return 5'd7;
    else if (ch == 1) return 5'd11;
    else              return 5'(14 + ch);
  endfunction

  assign pend             = irq & irq_en & {N_IRQ{mstatus_mie}};
  assign any_irq          = |pend;
  assign event_hit        = illinstr | mret | any_irq;
  assign base             = {csr_mtvec[XLEN-1:2], 2'b00};
  assign unused_mtvec_bit = csr_mtvec[1];

  // Lowest-index pending channel wins arbitration
  always_comb begin
    irq_found = 1'b0;
    irq_code  = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (pend[i] && !irq_found) begin
        irq_found = 1'b1;
        irq_code  = chan_code(i);
      end
    end
  end

  // Cause and redirect target for the event seen in IDLE
  always_comb begin
    cause_n  = '0;
    target_n = base;
    if (illinstr) begin
      cause_n = XLEN'(2);
    end else if (!mret) begin
      cause_n[4:0]      = irq_code;
      cause_n[XLEN-1]   = 1'b1;
      if ((VECTORED_EN != 0) && csr_mtvec[0])
        target_n = base + (XLEN'(irq_code) << 2);
    end
  end

  // Sequencer state, latched trap context, drain timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ret_q     <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (event_hit) begin
            ret_q    <= mret & ~illinstr;
            cause_q  <= cause_n;
            pc_q     <= cur_pc;
            target_q <= target_n;
            cnt_q    <= '0;
            state_q  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + 8'd1;
          if (drain_ack) begin
            state_q <= S_FLUSH;
          end else if (cnt_q == 8'(DRAIN_TMO - 1)) begin
            state_q   <= S_FLUSH;
            tmo_err_q <= 1'b1;
          end
        end
        S_FLUSH: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode; IDLE kill/stall is gated by reset so nothing leaks while held
  always_comb begin
    drain_req    = 1'b0;
    stall_f      = 1'b0;
    kill_d       = 1'b0;
    flush_pc_ena = 1'b0;
    flush_pc     = '0;
    mepc_wdata   = '0;
    mepc_we      = 1'b0;
    mcause_wdata = '0;
    mcause_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_f = event_hit & reset;
        kill_d  = event_hit & reset;
      end
      S_DRAIN: begin
        drain_req = 1'b1;
        stall_f   = 1'b1;
        kill_d    = 1'b1;
      end
      S_FLUSH: begin
        kill_d       = 1'b1;
        flush_pc_ena = 1'b1;
        if (ret_q) begin
          flush_pc = csr_mepc;
        end else begin
          flush_pc     = target_q;
          mepc_we      = 1'b1;
          mepc_wdata   = pc_q;
          mcause_we    = 1'b1;
          mcause_wdata = cause_q;
        end
      end
      default: ;
    endcase
  end

  assign drain_tmo_err = tmo_err_q;

endmodule

// File: tb/tb_cpu7_trap_ctrl.sv
// Directed bench for cpu7_trap_ctrl: trap, interrupt, mret, timeout, reset.
module tb_cpu7_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq, irq_en;
  logic        mstatus_mie, illinstr, mret, drain_ack;
  logic [31:0] cur_pc, csr_mtvec, csr_mepc;

  logic        drain_req, stall_f, kill_d, flush_pc_ena, mepc_we, mcause_we, drain_tmo_err;
  logic [31:0] flush_pc, mepc_wdata, mcause_wdata;

  logic        nv_drain_req, nv_stall_f, nv_kill_d, nv_flush_pc_ena, nv_mepc_we, nv_mcause_we, nv_tmo;
  logic [31:0] nv_flush_pc, nv_mepc_wdata, nv_mcause_wdata;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  cpu7_trap_ctrl #(.XLEN(32), .N_IRQ(4), .VECTORED_EN(1), .DRAIN_TMO(15)) dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_en(irq_en), .mstatus_mie(mstatus_mie),
    .illinstr(illinstr), .mret(mret), .cur_pc(cur_pc), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .drain_ack(drain_ack), .drain_req(drain_req), .stall_f(stall_f),
    .kill_d(kill_d), .flush_pc_ena(flush_pc_ena), .flush_pc(flush_pc),
    .mepc_wdata(mepc_wdata), .mepc_we(mepc_we), .mcause_wdata(mcause_wdata),
    .mcause_we(mcause_we), .drain_tmo_err(drain_tmo_err));

  cpu7_trap_ctrl #(.XLEN(32), .N_IRQ(4), .VECTORED_EN(0), .DRAIN_TMO(15)) dut_nv (
    .clk(clk), .reset(reset), .irq(irq), .irq_en(irq_en), .mstatus_mie(mstatus_mie),
    .illinstr(illinstr), .mret(mret), .cur_pc(cur_pc), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .drain_ack(drain_ack), .drain_req(nv_drain_req), .stall_f(nv_stall_f),
    .kill_d(nv_kill_d), .flush_pc_ena(nv_flush_pc_ena), .flush_pc(nv_flush_pc),
    .mepc_wdata(nv_mepc_wdata), .mepc_we(nv_mepc_we), .mcause_wdata(nv_mcause_wdata),
    .mcause_we(nv_mcause_we), .drain_tmo_err(nv_tmo));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; irq = '0; irq_en = '0; mstatus_mie = 1'b0; illinstr = 1'b1; mret = 1'b0;
    drain_ack = 1'b0; cur_pc = '0; csr_mtvec = '0; csr_mepc = '0;
    #2;
    chk("rst_kill_d", 32'(kill_d), 32'd0);
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    chk("rst_drain_req", 32'(drain_req), 32'd0);
    chk("rst_flush_ena", 32'(flush_pc_ena), 32'd0);
    chk("rst_tmo_err", 32'(drain_tmo_err), 32'd0);
    illinstr = 1'b0;
    cyc(); cyc();
    reset = 1'b1;

    // Illegal instruction, ack one cycle later
    illinstr = 1'b1; cur_pc = 32'h100; csr_mtvec = 32'h8000_0001; #1;
    chk("ill_ev_stall", 32'(stall_f), 32'd1);
    chk("ill_ev_kill", 32'(kill_d), 32'd1);
    chk("ill_ev_nodrain", 32'(drain_req), 32'd0);
    cyc(); illinstr = 1'b0; cur_pc = 32'h104; drain_ack = 1'b1; #1;
    chk("ill_drain_req", 32'(drain_req), 32'd1);
    chk("ill_drain_stall", 32'(stall_f), 32'd1);
    cyc(); drain_ack = 1'b0; #1;
    chk("ill_flush_ena", 32'(flush_pc_ena), 32'd1);
    chk("ill_flush_pc", flush_pc, 32'h8000_0000);
    chk("ill_mepc", mepc_wdata, 32'h100);
    chk("ill_mepc_we", 32'(mepc_we), 32'd1);
    chk("ill_mcause", mcause_wdata, 32'h2);
    chk("ill_mcause_we", 32'(mcause_we), 32'd1);
    chk("ill_flush_stall", 32'(stall_f), 32'd0);
    chk("ill_flush_nodrain", 32'(drain_req), 32'd0);
    cyc(); #1;
    chk("ill_post_flush_ena", 32'(flush_pc_ena), 32'd0);
    chk("ill_post_mepc_we", 32'(mepc_we), 32'd0);

    // Two irqs, ch0 wins; ack already high -> flush two cycles after event
    irq = 4'b0011; irq_en = 4'b1111; mstatus_mie = 1'b1; cur_pc = 32'h200; drain_ack = 1'b1; #1;
    chk("irq0_ev_stall", 32'(stall_f), 32'd1);
    cyc(); irq = 4'b0000; #1;
    chk("irq0_drain_req", 32'(drain_req), 32'd1);
    cyc(); #1;
    chk("irq0_flush_ena", 32'(flush_pc_ena), 32'd1);
    chk("irq0_mcause", mcause_wdata, 32'h8000_0007);
    chk("irq0_flush_pc", flush_pc, 32'h8000_001C);
    chk("irq0_mepc", mepc_wdata, 32'h200);
    chk("irq0_nv_flush_pc", nv_flush_pc, 32'h8000_0000);
    cyc();

    // ch1 in direct mode
    irq = 4'b0010; csr_mtvec = 32'h8000_0000; #1;
    cyc(); irq = 4'b0000; cyc(); #1;
    chk("irq1_mcause", mcause_wdata, 32'h8000_000B);
    chk("irq1_flush_pc", flush_pc, 32'h8000_0000);
    cyc();

    // ch2 vectored: code 16 -> offset 0x40
    irq = 4'b0100; csr_mtvec = 32'h8000_0001; #1;
    cyc(); irq = 4'b0000; cyc(); #1;
    chk("irq2_mcause", mcause_wdata, 32'h8000_0010);
    chk("irq2_flush_pc", flush_pc, 32'h8000_0040);
    cyc();

    // Masked interrupts never start a drain; stray ack in IDLE ignored
    irq = 4'b1111; irq_en = 4'b0000; mstatus_mie = 1'b1; n = 0;
    for (int i = 0; i < 3; i++) begin #1; n += int'(stall_f) + int'(drain_req); cyc(); end
    irq_en = 4'b1111; mstatus_mie = 1'b0;
    for (int i = 0; i < 3; i++) begin #1; n += int'(stall_f) + int'(drain_req); cyc(); end
    chk("masked_activity", 32'(n), 32'd0);
    irq = 4'b0000; mstatus_mie = 1'b1;

    // illinstr beats mret
    illinstr = 1'b1; mret = 1'b1; cur_pc = 32'h300; #1;
    cyc(); illinstr = 1'b0; mret = 1'b0; cyc(); #1;
    chk("prio_mcause", mcause_wdata, 32'h2);
    chk("prio_mepc_we", 32'(mepc_we), 32'd1);
    cyc();

    // mret beats irq; ack on third DRAIN cycle; mepc sampled in FLUSH
    drain_ack = 1'b0; mret = 1'b1; irq = 4'b0001; csr_mepc = 32'h999; n = 0; #1;
    n += int'(stall_f);
    cyc(); mret = 1'b0; irq = 4'b0000; #1; n += int'(stall_f);
    cyc(); #1; n += int'(stall_f);
    cyc(); drain_ack = 1'b1; #1; n += int'(stall_f);
    cyc(); drain_ack = 1'b0; csr_mepc = 32'h240; #1; n += int'(stall_f);
    chk("mret_stall_cycles", 32'(n), 32'd4);
    chk("mret_flush_ena", 32'(flush_pc_ena), 32'd1);
    chk("mret_flush_pc", flush_pc, 32'h240);
    chk("mret_mepc_we", 32'(mepc_we), 32'd0);
    chk("mret_mcause_we", 32'(mcause_we), 32'd0);
    cyc();

    // Drain timeout with ack held low
    illinstr = 1'b1; #1;
    cyc(); illinstr = 1'b0; n = 0; #1;
    while (drain_req && n < 40) begin n++; cyc(); #1; end
    chk("tmo_drain_cycles", 32'(n), 32'd15);
    chk("tmo_flush_ena", 32'(flush_pc_ena), 32'd1);
    chk("tmo_err_set", 32'(drain_tmo_err), 32'd1);
    cyc(); cyc(); #1;
    chk("tmo_err_sticky", 32'(drain_tmo_err), 32'd1);

    // Reset mid-DRAIN, then held irq re-traps and re-triggers back-to-back
    irq = 4'b0001; #1;
    cyc(); #1;
    chk("rstmid_in_drain", 32'(drain_req), 32'd1);
    reset = 1'b0; #1;
    chk("rstmid_drain_req", 32'(drain_req), 32'd0);
    chk("rstmid_stall_f", 32'(stall_f), 32'd0);
    chk("rstmid_kill_d", 32'(kill_d), 32'd0);
    chk("rstmid_tmo_err", 32'(drain_tmo_err), 32'd0);
    cyc(); reset = 1'b1; drain_ack = 1'b1; #1;
    chk("retrap_stall", 32'(stall_f), 32'd1);
    cyc(); cyc(); #1;
    chk("retrap_mcause", mcause_wdata, 32'h8000_0007);
    cyc(); #1;
    chk("b2b_stall", 32'(stall_f), 32'd1);
    irq = 4'b0000;
    cyc(); cyc(); cyc(); #1;
    chk("final_idle_flush_ena", 32'(flush_pc_ena), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
